// File: rtl/iotdf_ctrl.sv
// Input-side sequencer for the IoT data-filtering datapath: assembles 16-byte
// words from the serial byte stream and drives the round/word control bus.
module iotdf_ctrl #(
  parameter int BYTES_PER_WORD  = 16,
  parameter int WORDS_PER_ROUND = 8,
  parameter int NUM_ROUNDS      = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_en,
  input  logic [7:0]   iot_in,
  input  logic [2:0]   fn_sel,
  output logic         busy,
  output logic [2:0]   state,
  output logic [5:0]   cnt,
  output logic [7:0]   cycle_cnt,
  output logic         flag,
  output logic [2:0]   fn_q,
  output logic [127:0] data_word,
  output logic         word_valid,
  output logic         finish
);

  localparam int RW = (NUM_ROUNDS > 1) ? $clog2(NUM_ROUNDS) : 1;
  localparam logic [5:0]    CNT_MAX   = 6'(BYTES_PER_WORD - 1);
  localparam logic [7:0]    WORD_MAX  = 8'(WORDS_PER_ROUND - 1);
  localparam logic [RW-1:0] ROUND_MAX = RW'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_LOAD = 3'b001,
    S_OUT  = 3'b010,
    S_DONE = 3'b011
  } state_t;

  state_t        st, st_nxt;
  logic [RW-1:0] round_cnt;
  logic          take, last_byte, last_word, last_round;

  assign take       = (st == S_LOAD) && in_en;
  assign last_byte  = (cnt == CNT_MAX);
  assign last_word  = (cycle_cnt == WORD_MAX);
  assign last_round = (round_cnt == ROUND_MAX);
  assign state      = st;

  always_comb begin
    st_nxt = st;
    case (st)
      S_IDLE: st_nxt = S_LOAD;
      S_LOAD: if (take && last_byte && last_word) st_nxt = S_OUT;
      S_OUT:  st_nxt = last_round ? S_DONE : S_LOAD;
      S_DONE: st_nxt = S_DONE;
      default: st_nxt = S_IDLE;
    endcase
  end

  // busy/finish are registered from the state being entered, so busy is
  // already high in the OUT cycle and no byte can slip in there.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= S_IDLE;
      busy   <= 1'b1;
      finish <= 1'b0;
    end else begin
      st     <= st_nxt;
      busy   <= (st_nxt != S_LOAD);
      finish <= (st_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      cycle_cnt  <= '0;
      flag       <= 1'b0;
      fn_q       <= '0;
      data_word  <= '0;
      word_valid <= 1'b0;
      round_cnt  <= '0;
    end else begin
      word_valid <= 1'b0;
      if (st == S_IDLE) fn_q <= fn_sel;
      if (take) begin
        data_word <= {data_word[119:0], iot_in};
        if (last_byte) begin
          cnt        <= '0;
          word_valid <= 1'b1;
          if (!last_word) cycle_cnt <= cycle_cnt + 8'd1;
        end else begin
          cnt <= cnt + 6'd1;
        end
      end
      if (st == S_OUT) begin
        cycle_cnt <= '0;
        flag      <= 1'b1;
        round_cnt <= round_cnt + 1'b1;
      end
    end
  end

endmodule
